// File: rtl/traffic_light_ctrl_param.sv
// Two-road intersection controller: prescaled phase timing, demand-actuated
// rest-on-green, all-red clearance after each yellow and a flashing-yellow mode.
module traffic_light_ctrl_param #(
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 1,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ns_sensor,
  input  logic             ew_sensor,
  input  logic             flash_en,
  output logic [2:0]       NS_light,
  output logic [2:0]       EW_light,
  output logic [CNT_W-1:0] time_left,
  output logic [2:0]       phase
);

  localparam logic [2:0] RST_RED = 3'd0;
  localparam logic [2:0] NS_G    = 3'd1;
  localparam logic [2:0] NS_Y    = 3'd2;
  localparam logic [2:0] RED_A   = 3'd3;
  localparam logic [2:0] EW_G    = 3'd4;
  localparam logic [2:0] EW_Y    = 3'd5;
  localparam logic [2:0] RED_B   = 3'd6;
  localparam logic [2:0] FLASH   = 3'd7;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_D = 3'b000;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LD    = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE   = PW'(1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_ZERO    = '0;

  logic [2:0]       state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [PW-1:0]    presc;
  logic             flash_on, flash_next;
  logic             ew_dem, ew_dem_next;
  logic             ns_dem, ns_dem_next;
  logic [2:0]       ns_lamp_next, ew_lamp_next;
  logic             tick, expire;

  assign tick   = (presc == '0);
  assign expire = tick && (timer == T_ZERO);

  always_comb begin
    state_next = state;
    timer_next = (tick && timer != T_ZERO) ? timer - T_ONE : timer;
    flash_next = flash_on;
    case (state)
      RST_RED, RED_A, RED_B: begin
        if (expire) begin
          if (flash_en) begin
            state_next = FLASH;
            timer_next = T_ZERO;
            flash_next = 1'b1;
          end else begin
            state_next = (state == RED_A) ? EW_G : NS_G;
            timer_next = GREEN_LD;
          end
        end
      end
      NS_G: begin
        // Timer sits at 0 while resting on green until the cross road asks.
        if (expire && ew_dem) begin
          state_next = NS_Y;
          timer_next = YELLOW_LD;
        end
      end
      NS_Y: begin
        if (expire) begin
          state_next = RED_A;
          timer_next = ALLRED_LD;
        end
      end
      EW_G: begin
        if (expire && ns_dem) begin
          state_next = EW_Y;
          timer_next = YELLOW_LD;
        end
      end
      EW_Y: begin
        if (expire) begin
          state_next = RED_B;
          timer_next = ALLRED_LD;
        end
      end
      FLASH: begin
        timer_next = T_ZERO;
        if (tick) begin
          if (!flash_en) begin
            state_next = RST_RED;
            timer_next = ALLRED_LD;
          end else begin
            flash_next = ~flash_on;
          end
        end
      end
      default: begin
        state_next = RST_RED;
        timer_next = ALLRED_LD;
      end
    endcase
  end

  // Entering a green clears its request; the clear takes priority over a new set.
  always_comb begin
    if (state_next == EW_G && state != EW_G)
      ew_dem_next = 1'b0;
    else
      ew_dem_next = ew_dem | (ew_sensor && state != EW_G);
    if (state_next == NS_G && state != NS_G)
      ns_dem_next = 1'b0;
    else
      ns_dem_next = ns_dem | (ns_sensor && state != NS_G);
  end

  always_comb begin
    ns_lamp_next = LAMP_R;
    ew_lamp_next = LAMP_R;
    case (state_next)
      NS_G:    ns_lamp_next = LAMP_G;
      NS_Y:    ns_lamp_next = LAMP_Y;
      EW_G:    ew_lamp_next = LAMP_G;
      EW_Y:    ew_lamp_next = LAMP_Y;
      FLASH: begin
        ns_lamp_next = flash_next ? LAMP_Y : LAMP_D;
        ew_lamp_next = flash_next ? LAMP_Y : LAMP_D;
      end
      default: begin
        ns_lamp_next = LAMP_R;
        ew_lamp_next = LAMP_R;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_RED;
      timer    <= ALLRED_LD;
      presc    <= PRE_LD;
      flash_on <= 1'b0;
      ew_dem   <= 1'b0;
      ns_dem   <= 1'b0;
      NS_light <= LAMP_R;
      EW_light <= LAMP_R;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      presc    <= tick ? PRE_LD : presc - PRE_ONE;
      flash_on <= flash_next;
      ew_dem   <= ew_dem_next;
      ns_dem   <= ns_dem_next;
      NS_light <= ns_lamp_next;
      EW_light <= ew_lamp_next;
    end
  end

  assign time_left = timer;
  assign phase     = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench: per-cycle vector table for the main sequences plus a
// hand-written run of a TICK_DIV=5 instance.
module tb_traffic_light_ctrl_param;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  typedef struct {
    logic       rst_before;
    logic       ns;
    logic       ew;
    logic       fl;
    logic [2:0] ens;
    logic [2:0] eew;
    int         etl;
    int         eph;
  } vec_t;

  vec_t vecs[$];
  int   compared = 0;
  int   mismatched = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst5 = 1'b1;
  logic       ns_s = 1'b0, ew_s = 1'b0, fl = 1'b0;
  logic [2:0] ns_l, ew_l, ph, ns_l5, ew_l5, ph5;
  logic [7:0] tl, tl5;

  always #5 clk = ~clk;

  traffic_light_ctrl_param #(.CNT_W(8), .TICK_DIV(1), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1)) dut (
    .clk(clk), .rst(rst), .ns_sensor(ns_s), .ew_sensor(ew_s), .flash_en(fl),
    .NS_light(ns_l), .EW_light(ew_l), .time_left(tl), .phase(ph));

  traffic_light_ctrl_param #(.CNT_W(8), .TICK_DIV(5), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1)) dut5 (
    .clk(clk), .rst(rst5), .ns_sensor(ns_s), .ew_sensor(ew_s), .flash_en(fl),
    .NS_light(ns_l5), .EW_light(ew_l5), .time_left(tl5), .phase(ph5));

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic n, input logic e, input logic f,
                     input logic [2:0] a, input logic [2:0] b, input int t, input int p);
    vec_t v;
    v.rst_before = r; v.ns = n; v.ew = e; v.fl = f;
    v.ens = a; v.eew = b; v.etl = t; v.eph = p;
    vecs.push_back(v);
  endtask

  // Reset is asserted between edges so its asynchronous effect is checked before any clk.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_ns", int'(ns_l), int'(R));
    chk("rst_async_ew", int'(ew_l), int'(R));
    chk("rst_async_ph", int'(ph), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_tl", int'(tl), 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Sequence with both sensors held 1: full 14-clk cycle, continued into EW_G, then reset mid EW_G.
    add(1,1,1,0, G,R,3,1); add(0,1,1,0, G,R,2,1); add(0,1,1,0, G,R,1,1); add(0,1,1,0, G,R,0,1);
    add(0,1,1,0, Y,R,1,2); add(0,1,1,0, Y,R,0,2); add(0,1,1,0, R,R,0,3);
    add(0,1,1,0, R,G,3,4); add(0,1,1,0, R,G,2,4); add(0,1,1,0, R,G,1,4); add(0,1,1,0, R,G,0,4);
    add(0,1,1,0, R,Y,1,5); add(0,1,1,0, R,Y,0,5); add(0,1,1,0, R,R,0,6);
    add(0,1,1,0, G,R,3,1); add(0,1,1,0, G,R,2,1); add(0,1,1,0, G,R,1,1); add(0,1,1,0, G,R,0,1);
    add(0,1,1,0, Y,R,1,2); add(0,1,1,0, Y,R,0,2); add(0,1,1,0, R,R,0,3);
    add(0,1,1,0, R,G,3,4); add(0,1,1,0, R,G,2,4);
    add(1,1,1,0, G,R,3,1); add(0,1,1,0, G,R,2,1);
    // No demand: rest on NS_G, ew pulse releases it, pulse in NS_Y does not earn a second EW_G.
    add(1,0,0,0, G,R,3,1); add(0,0,0,0, G,R,2,1); add(0,0,0,0, G,R,1,1); add(0,0,0,0, G,R,0,1);
    add(0,0,0,0, G,R,0,1); add(0,0,0,0, G,R,0,1); add(0,0,1,0, G,R,0,1);
    add(0,0,0,0, Y,R,1,2); add(0,0,1,0, Y,R,0,2); add(0,0,0,0, R,R,0,3);
    add(0,0,0,0, R,G,3,4); add(0,0,0,0, R,G,2,4); add(0,0,0,0, R,G,1,4); add(0,0,0,0, R,G,0,4);
    add(0,0,0,0, R,G,0,4); add(0,0,0,0, R,G,0,4); add(0,1,0,0, R,G,0,4);
    add(0,0,0,0, R,Y,1,5); add(0,0,0,0, R,Y,0,5); add(0,0,0,0, R,R,0,6);
    add(0,0,0,0, G,R,3,1); add(0,0,0,0, G,R,2,1); add(0,0,0,0, G,R,1,1); add(0,0,0,0, G,R,0,1);
    add(0,0,0,0, G,R,0,1);
    // Flash requested mid NS_G: green, yellow and all-red finish first.
    add(1,1,1,0, G,R,3,1); add(0,1,1,1, G,R,2,1); add(0,1,1,1, G,R,1,1); add(0,1,1,1, G,R,0,1);
    add(0,1,1,1, Y,R,1,2); add(0,1,1,1, Y,R,0,2); add(0,1,1,1, R,R,0,3);
    add(0,1,1,1, Y,Y,0,7); add(0,1,1,1, D,D,0,7); add(0,1,1,1, Y,Y,0,7);
    add(0,1,1,0, R,R,0,0); add(0,1,1,0, G,R,3,1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      @(negedge clk);
      ns_s = vecs[i].ns; ew_s = vecs[i].ew; fl = vecs[i].fl;
      @(posedge clk);
      #1;
      $display("vec %0d: ns=%b ew=%b fl=%b -> NS=%b EW=%b tl=%0d ph=%0d",
               i, vecs[i].ns, vecs[i].ew, vecs[i].fl, ns_l, ew_l, tl, ph);
      chk($sformatf("v%0d_ns", i), int'(ns_l), int'(vecs[i].ens));
      chk($sformatf("v%0d_ew", i), int'(ew_l), int'(vecs[i].eew));
      chk($sformatf("v%0d_tl", i), int'(tl), vecs[i].etl);
      chk($sformatf("v%0d_ph", i), int'(ph), vecs[i].eph);
    end

    // TICK_DIV=5 instance: first tick 5 clks after release, each green tick lasts 5 clks.
    @(negedge clk);
    ns_s = 1'b1; ew_s = 1'b1; fl = 1'b0;
    #1;
    chk("d5_rst_ns", int'(ns_l5), int'(R));
    chk("d5_rst_ph", int'(ph5), 0);
    @(posedge clk);
    #2 rst5 = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      #1;
      $display("d5 edge %0d: NS=%b EW=%b tl=%0d ph=%0d", e, ns_l5, ew_l5, tl5, ph5);
      if (e == 4) chk("d5_e4_ph", int'(ph5), 0);
      if (e == 5) begin
        chk("d5_e5_ph", int'(ph5), 1);
        chk("d5_e5_tl", int'(tl5), 3);
        chk("d5_e5_ns", int'(ns_l5), int'(G));
      end
      if (e == 9)  chk("d5_e9_tl", int'(tl5), 3);
      if (e == 10) chk("d5_e10_tl", int'(tl5), 2);
      if (e == 24) begin
        chk("d5_e24_ph", int'(ph5), 1);
        chk("d5_e24_tl", int'(tl5), 0);
      end
      if (e == 25) begin
        chk("d5_e25_ph", int'(ph5), 2);
        chk("d5_e25_tl", int'(tl5), 1);
        chk("d5_e25_ns", int'(ns_l5), int'(Y));
        chk("d5_e25_ew", int'(ew_l5), int'(R));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
